core_pipe_exec_div: RTL
=======================

# core_pipe_exec_div

Iterative radix-2 restoring divider for the RV64 M-extension DIV/DIVU/REM/REMU and their W variants. It sits inside the execute-stage multiply/divide unit, which instantiates it and muxes its `rd` onto the shared MDU result path (`result_div`) whenever a divide-class op is selected. It uses the same operand-hold, ready-when-done, flush-to-abort handshake as the multiplier, so the MDU ORs the two `ready` signals.

## Interface

**Parameters**
- `XLEN`, 64: datapath width. Word ops always use 32 bits.

**Ports**
- `g_clk` in 1: clock.
- `g_resetn` in 1: reset, synchronous, active-low. Clock is `g_clk`.
- `flush` in 1: abort any operation and return to IDLE.
- `valid` in 1: request present. `op_*` and `rs1`/`rs2` are held stable while it is high.
- `op_word` in 1: operate on `rs1[31:0]` and `rs2[31:0]`; sign-extend the result from bit 31.
- `op_div` in 1: signed quotient.
- `op_divu` in 1: unsigned quotient.
- `op_rem` in 1: signed remainder.
- `op_remu` in 1: unsigned remainder.
- `rs1` in XLEN: dividend.
- `rs2` in XLEN: divisor.
- `ready` out 1: `rd` is valid.
- `rd` out XLEN: result, driven from a register.

## Operation

**Start condition**
- `start = valid && (op_div|op_divu|op_rem|op_remu) && state==IDLE && !flush`.

**FSM states**
- IDLE
  - `start` with a zero divisor (over the operand width) goes to DONE.
  - Any other `start` goes to RUN.
- RUN
  - `ctr` decrements once per cycle.
  - When `ctr==1` and that step is performed, go to DONE.
- DONE
  - Hold `ready=1` and `rd` stable while `valid` stays high.
  - Go to IDLE when `valid==0`.
- From any state, `flush` or `!g_resetn` goes to IDLE next cycle. `flush` beats `start` in the same cycle.

**On start, latch**
- `signed = op_div|op_rem`.
- `want_rem = op_rem|op_remu`.
- `op_word`.
- `neg_q = signed && sign(a)!=sign(b)`.
- `neg_r = signed && sign(a)`.
- `|a|` into the quotient/dividend shift register and `|b|` into the divisor register. Magnitudes are taken only when `signed`; widths are 32 or XLEN per `op_word`; upper bits are zeroed.
- `acc` (XLEN+1 bits) = 0.
- `ctr` = 32 or XLEN.

**Each RUN step**
- `trial = {acc[XL:0], qreg[msb]} - {1'b0, divisor}`.
- If `trial` is non-negative: `acc=trial` and shift 1 into `qreg`.
- Otherwise: `acc = {acc[XL:0], qreg[msb]}` and shift 0 into `qreg`.
- `msb` is bit 31 for word ops, XL otherwise.

**On the RUN→DONE edge**, register the result:
- `res = want_rem ? (neg_r ? -acc : acc) : (neg_q ? -q : q)`.
- For word ops, `rd = {{32{res[31]}}, res[31:0]}`. This applies to DIVUW/REMUW too.

**Divide by zero (IDLE→DONE)**
- Quotient is all ones: `-1` sign-extended to XLEN.
- Remainder is the dividend, sign-extended from bit 31 for word ops.

**Signed overflow** (MIN / -1)
- Goes through the normal path.
- Quotient must equal MIN, sign-extended for word ops; remainder must be 0.

**Reset**: state=IDLE, `ready=0`, `rd=0`, `ctr=0`, `acc=0`.

## Timing

- Cycle 0 is the `start` cycle.
- Normal operation: RUN occupies cycles 1..N, with N = 32 (word) or XLEN. `ready` first rises in cycle N+1 (33 for word, 65 for 64-bit).
- Divide by zero: `ready` rises in cycle 1.
- `ready` is 0 in IDLE and RUN, and is registered (no combinational path from inputs).
- `rd` changes only on entry to DONE, reset, or flush (flush clears it to 0).
- Back-to-back ops: `valid` must drop for at least one cycle (DONE→IDLE) before the next `start`, so the minimum spacing is N+3 cycles.
- Flush mid-RUN: cycle after flush is IDLE with `ready=0`. A new `valid` starts a fresh op with full latency, and no stale `acc`/`qreg` state leaks into it.

## Test plan

- **DIV/REM, 64-bit signed:** `rs1=0xFFFF_FFFF_FFFF_FFEC` (-20), `rs2=3` -> `ready` in cycle 65; DIV `rd=0xFFFF_FFFF_FFFF_FFFA` (-6), REM `rd=0xFFFF_FFFF_FFFF_FFFE` (-2).
- **Divide by zero, unsigned:** `rs1=0x1234`, `rs2=0` -> `ready` in cycle 1; DIVU `rd=0xFFFF_FFFF_FFFF_FFFF`, REMU `rd=0x1234`.
- **Signed overflow:**
  - 64-bit: `rs1=0x8000_0000_0000_0000`, `rs2=0xFFFF_FFFF_FFFF_FFFF` -> DIV `rd=0x8000_0000_0000_0000`, REM `rd=0`.
  - DIVW: `rs1=0x8000_0000`, `rs2=-1` -> `rd=0xFFFF_FFFF_8000_0000`.
- **Word ops:**
  - DIVUW: `rs1=0xFFFF_FFFF_8000_0000`, `rs2=2` -> `ready` in cycle 33, `rd=0x0000_0000_4000_0000`.
  - REMW: `rs1=0xFFFF_FFF9` (-7), `rs2=2` -> `rd=0xFFFF_FFFF_FFFF_FFFF`.
- **Flush mid-operation:** flush in cycle 10 of a 64-bit DIVU `100/7` -> `ready` stays 0. Reissuing DIVU `100/7` gives `rd=14` in exactly cycle 65 of the new op.
- **Reset and handshake:** assert `g_resetn=0` in cycle 20 of a RUN -> next cycle `ready=0`, `rd=0`. Separately, hold `valid` in DONE for 5 cycles -> `rd` stable and no restart; drop `valid` -> IDLE.

Source files
------------

// File: rtl/core_pipe_exec_div.sv
// Iterative radix-2 restoring divider for RV64 DIV/DIVU/REM/REMU and W variants.
// Operands held while valid is high; ready/rd registered, held in DONE until valid drops.
module core_pipe_exec_div #(
    parameter int unsigned XLEN = 64
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic            flush,
    input  logic            valid,
    input  logic            op_word,
    input  logic            op_div,
    input  logic            op_divu,
    input  logic            op_rem,
    input  logic            op_remu,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            ready,
    output logic [XLEN-1:0] rd
);

    localparam int unsigned XL = XLEN - 1;
    localparam int unsigned UW = XLEN - 32;
    localparam int unsigned CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   ctr;
    logic [XLEN:0]   acc;
    logic [XLEN-1:0] qreg;
    logic [XLEN-1:0] divisor;
    logic            l_want_rem;
    logic            l_word;
    logic            l_neg_q;
    logic            l_neg_r;

    logic            start_c;
    logic            is_signed_c;
    logic            a_neg_c;
    logic            b_neg_c;
    logic [XLEN-1:0] a_sel_c;
    logic [XLEN-1:0] b_sel_c;
    logic [XLEN-1:0] a_inv_c;
    logic [XLEN-1:0] b_inv_c;
    logic [XLEN-1:0] a_mag_c;
    logic [XLEN-1:0] b_mag_c;
    logic            b_zero_c;
    logic [XLEN-1:0] dz_res_c;

    // Operand selection, magnitudes and divide-by-zero result for the start cycle.
    always_comb begin
        start_c     = valid && (op_div || op_divu || op_rem || op_remu) &&
                      (state == S_IDLE) && !flush;
        is_signed_c = op_div || op_rem;
        a_sel_c     = op_word ? {{UW{1'b0}}, rs1[31:0]} : rs1;
        b_sel_c     = op_word ? {{UW{1'b0}}, rs2[31:0]} : rs2;
        a_neg_c     = is_signed_c && (op_word ? rs1[31] : rs1[XL]);
        b_neg_c     = is_signed_c && (op_word ? rs2[31] : rs2[XL]);
        a_inv_c     = -a_sel_c;
        b_inv_c     = -b_sel_c;
        a_mag_c     = a_sel_c;
        b_mag_c     = b_sel_c;
        if (a_neg_c) begin
            a_mag_c = op_word ? {{UW{1'b0}}, a_inv_c[31:0]} : a_inv_c;
        end
        if (b_neg_c) begin
            b_mag_c = op_word ? {{UW{1'b0}}, b_inv_c[31:0]} : b_inv_c;
        end
        b_zero_c = (b_sel_c == '0);
        dz_res_c = '1;
        if (op_rem || op_remu) begin
            dz_res_c = op_word ? {{UW{rs1[31]}}, rs1[31:0]} : rs1;
        end
    end

    logic            q_msb_c;
    logic [XLEN+1:0] shifted_c;
    logic [XLEN+1:0] trial_c;
    logic [XLEN:0]   acc_nx_c;
    logic [XLEN-1:0] q_nx_c;
    logic [XLEN-1:0] q_res_c;
    logic [XLEN-1:0] r_res_c;
    logic [XLEN-1:0] res_c;
    logic [XLEN-1:0] fin_c;

    // One restoring step plus the sign fix-up applied on the final step.
    always_comb begin
        q_msb_c   = l_word ? qreg[31] : qreg[XL];
        shifted_c = {acc, q_msb_c};
        trial_c   = shifted_c - {2'b00, divisor};
        acc_nx_c  = trial_c[XLEN+1] ? shifted_c[XLEN:0] : trial_c[XLEN:0];
        q_nx_c    = {qreg[XL-1:0], ~trial_c[XLEN+1]};
        q_res_c   = l_neg_q ? -q_nx_c : q_nx_c;
        r_res_c   = l_neg_r ? -acc_nx_c[XL:0] : acc_nx_c[XL:0];
        res_c     = l_want_rem ? r_res_c : q_res_c;
        fin_c     = l_word ? {{UW{res_c[31]}}, res_c[31:0]} : res_c;
    end

    // Control FSM and datapath registers.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state      <= S_IDLE;
            ready      <= 1'b0;
            rd         <= '0;
            ctr        <= '0;
            acc        <= '0;
            qreg       <= '0;
            divisor    <= '0;
            l_want_rem <= 1'b0;
            l_word     <= 1'b0;
            l_neg_q    <= 1'b0;
            l_neg_r    <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
            ready <= 1'b0;
            rd    <= '0;
            ctr   <= '0;
            acc   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_c) begin
                        l_want_rem <= op_rem || op_remu;
                        l_word     <= op_word;
                        l_neg_q    <= a_neg_c != b_neg_c;
                        l_neg_r    <= a_neg_c;
                        qreg       <= a_mag_c;
                        divisor    <= b_mag_c;
                        acc        <= '0;
                        ctr        <= op_word ? CW'(32) : CW'(XLEN);
                        if (b_zero_c) begin
                            state <= S_DONE;
                            ready <= 1'b1;
                            rd    <= dz_res_c;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    acc  <= acc_nx_c;
                    qreg <= q_nx_c;
                    ctr  <= ctr - CW'(1);
                    if (ctr == CW'(1)) begin
                        state <= S_DONE;
                        ready <= 1'b1;
                        rd    <= fin_c;
                    end
                end
                S_DONE: begin
                    if (!valid) begin
                        state <= S_IDLE;
                        ready <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
